// File: rtl/mem_access.sv
// Load/store unit between execute and writeback.
// Accepts one instruction at a time and either passes the ALU result through
// or runs a single data-bus transaction. Load data is formatted with sign or
// zero extension; stores are lane-aligned with matching byte strobes.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_misalign
);

  typedef enum logic [1:0] {IDLE, BUS, OUT} state_t;

  state_t state, state_next;

  logic [3:0]  op_q;
  logic [63:0] addr_q;
  logic [63:0] data_q;
  logic [1:0]  size_q;
  logic [7:0]  strobe_q;
  logic        wen_q;
  logic [63:0] result_q;
  logic [4:0]  rd_q;
  logic        out_wen_q;
  logic        misalign_q;

  logic        in_mem;
  logic        in_store;
  logic [1:0]  in_size;
  logic [2:0]  low_mask;
  logic [7:0]  size_mask;
  logic        in_misalign;

  logic [63:0] raw;
  logic [63:0] load_val;

  // Decode the incoming opcode into access kind, size and alignment check.
  always_comb begin
    in_mem    = 1'b0;
    in_store  = 1'b0;
    in_size   = 2'd0;
    low_mask  = 3'b000;
    size_mask = 8'h01;
    case (in_op)
      4'd1, 4'd5: begin in_mem = 1'b1; in_size = 2'd0; end
      4'd2, 4'd6: begin in_mem = 1'b1; in_size = 2'd1; end
      4'd3, 4'd7: begin in_mem = 1'b1; in_size = 2'd2; end
      4'd4:       begin in_mem = 1'b1; in_size = 2'd3; end
      4'd8:       begin in_mem = 1'b1; in_store = 1'b1; in_size = 2'd0; end
      4'd9:       begin in_mem = 1'b1; in_store = 1'b1; in_size = 2'd1; end
      4'd10:      begin in_mem = 1'b1; in_store = 1'b1; in_size = 2'd2; end
      4'd11:      begin in_mem = 1'b1; in_store = 1'b1; in_size = 2'd3; end
      default:    ;
    endcase
    case (in_size)
      2'd0:    begin low_mask = 3'b000; size_mask = 8'h01; end
      2'd1:    begin low_mask = 3'b001; size_mask = 8'h03; end
      2'd2:    begin low_mask = 3'b011; size_mask = 8'h0F; end
      default: begin low_mask = 3'b111; size_mask = 8'hFF; end
    endcase
    in_misalign = in_mem && ((in_addr[2:0] & low_mask) != 3'b000);
  end

  // Shift the response down to the access offset and extend per load type.
  always_comb begin
    raw = dresp_data >> {addr_q[2:0], 3'b000};
    case (op_q)
      4'd1:    load_val = {{56{raw[7]}},  raw[7:0]};
      4'd2:    load_val = {{48{raw[15]}}, raw[15:0]};
      4'd3:    load_val = {{32{raw[31]}}, raw[31:0]};
      4'd5:    load_val = {56'd0, raw[7:0]};
      4'd6:    load_val = {48'd0, raw[15:0]};
      4'd7:    load_val = {32'd0, raw[31:0]};
      default: load_val = raw;
    endcase
  end

  // State register; reset drops any in-flight bus request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: pass-through and misaligned ops skip the bus.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (in_mem && !in_misalign) ? BUS : OUT;
      BUS:  if (dresp_ok) state_next = OUT;
      OUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch request fields on accept, result on bus completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= 4'd0;
      addr_q     <= 64'd0;
      data_q     <= 64'd0;
      size_q     <= 2'd0;
      strobe_q   <= 8'd0;
      wen_q      <= 1'b0;
      result_q   <= 64'd0;
      rd_q       <= 5'd0;
      out_wen_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rd_q       <= in_rd;
            misalign_q <= 1'b0;
            if (!in_mem) begin
              result_q  <= in_addr;
              out_wen_q <= in_wen;
            end else if (in_misalign) begin
              misalign_q <= 1'b1;
              result_q   <= in_addr;
              out_wen_q  <= 1'b0;
            end else begin
              op_q      <= in_op;
              addr_q    <= in_addr;
              size_q    <= in_size;
              wen_q     <= in_wen;
              out_wen_q <= 1'b0;
              strobe_q  <= in_store ? (size_mask << in_addr[2:0]) : 8'd0;
              data_q    <= in_store ? (in_wdata << {in_addr[2:0], 3'b000}) : 64'd0;
            end
          end
        end
        BUS: begin
          if (dresp_ok) begin
            if (op_q >= 4'd8) begin
              result_q  <= addr_q;
              out_wen_q <= 1'b0;
            end else begin
              result_q  <= load_val;
              out_wen_q <= wen_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign dreq_valid   = (state == BUS);
  assign out_valid    = (state == OUT);
  assign dreq_addr    = addr_q;
  assign dreq_size    = {1'b0, size_q};
  assign dreq_strobe  = strobe_q;
  assign dreq_data    = data_q;
  assign out_result   = result_q;
  assign out_rd       = rd_q;
  assign out_wen      = out_wen_q;
  assign out_misalign = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized
// instructions compared against an arithmetic model of the access rules.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_misalign;

  int checkCount = 0;
  int failCount  = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_wen(in_wen),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .out_misalign(out_misalign)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference: what the unit should do with one instruction, from the rules.
  function automatic void model(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic wenIn, input logic [63:0] resp,
                                output bit useBus, output logic [2:0] size, output logic [7:0] strobe,
                                output logic [63:0] data, output logic [63:0] result,
                                output logic wenOut, output logic mis);
    int bytes, off;
    bit isMem, isStore, isSigned;
    logic [15:0] s;
    logic [63:0] rawv, mask;
    isMem = (op >= 1) && (op <= 11);
    isStore = (op >= 8) && (op <= 11);
    isSigned = (op >= 1) && (op <= 3);
    case (op)
      1, 5, 8:  size = 0;
      2, 6, 9:  size = 1;
      3, 7, 10: size = 2;
      default:  size = 3;
    endcase
    bytes = 1 << size;
    off = int'(addr % 8);
    strobe = 0; data = 0; mis = 0; useBus = 0;
    if (!isMem) begin
      result = addr; wenOut = wenIn;
    end else if ((addr % bytes) != 0) begin
      mis = 1; result = addr; wenOut = 0;
    end else begin
      useBus = 1;
      if (isStore) begin
        s = ((16'd1 << bytes) - 16'd1) << off;
        strobe = s[7:0];
        data = wdata << (8 * off);
        result = addr; wenOut = 0;
      end else begin
        rawv = resp >> (8 * off);
        if (bytes == 8) result = rawv;
        else begin
          mask = (64'd1 << (8 * bytes)) - 64'd1;
          result = rawv & mask;
          if (isSigned && rawv[8 * bytes - 1]) result = result | ~mask;
        end
        wenOut = wenIn;
      end
    end
  endfunction

  // Run one instruction end to end, checking every cycle of the handshake.
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [4:0] rd, input logic wen, input logic [63:0] resp,
                               input int respDelay, input int readyDelay);
    bit useBus;
    logic [2:0] eSize;
    logic [7:0] eStrobe;
    logic [63:0] eData, eResult;
    logic eWen, eMis;
    model(op, addr, wdata, wen, resp, useBus, eSize, eStrobe, eData, eResult, eWen, eMis);
    checkOutput("in_ready_idle", in_ready, 1);
    in_valid = 1; in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd; in_wen = wen;
    @(negedge clk);
    in_valid = 0; in_op = 4'($urandom); in_addr = rand64(); in_wdata = rand64();
    in_rd = 5'($urandom); in_wen = 1'($urandom);
    if (useBus) begin
      for (int c = 0; c <= respDelay; c++) begin
        checkOutput("dreq_valid", dreq_valid, 1);
        checkOutput("dreq_addr", dreq_addr, addr);
        checkOutput("dreq_size", dreq_size, eSize);
        checkOutput("dreq_strobe", dreq_strobe, eStrobe);
        checkOutput("dreq_data", dreq_data, eData);
        checkOutput("bus_out_valid", out_valid, 0);
        checkOutput("bus_in_ready", in_ready, 0);
        if (c == respDelay) begin
          dresp_ok = 1; dresp_data = resp;
        end
        @(negedge clk);
        dresp_ok = 0; dresp_data = rand64();
      end
    end
    for (int c = 0; c <= readyDelay; c++) begin
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_result", out_result, eResult);
      checkOutput("out_rd", out_rd, rd);
      checkOutput("out_wen", out_wen, eWen);
      checkOutput("out_misalign", out_misalign, eMis);
      checkOutput("out_dreq_valid", dreq_valid, 0);
      checkOutput("out_in_ready", in_ready, 0);
      if (c == readyDelay) out_ready = 1;
      else begin
        out_ready = 0; dresp_ok = 1'($urandom); dresp_data = rand64();
      end
      @(negedge clk);
      out_ready = 0; dresp_ok = 0;
    end
    checkOutput("done_out_valid", out_valid, 0);
    checkOutput("done_in_ready", in_ready, 1);
  endtask

  initial begin
    reset = 1; in_valid = 0; in_op = 0; in_addr = 0; in_wdata = 0; in_rd = 0; in_wen = 0;
    dresp_ok = 0; dresp_data = 0; out_ready = 0;
    #2;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_dreq_valid", dreq_valid, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_wen", out_wen, 0);
    checkOutput("rst_out_misalign", out_misalign, 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_dreq_addr", dreq_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    applyStimulus(4'd0, 64'h1234, 64'h0, 5'd5, 1'b1, 64'h0, 0, 0);
    applyStimulus(4'd1, 64'h1003, 64'h0, 5'd7, 1'b1, 64'h0000_0000_8000_0000, 1, 0);
    applyStimulus(4'd5, 64'h1003, 64'h0, 5'd7, 1'b1, 64'h0000_0000_8000_0000, 0, 1);
    applyStimulus(4'd9, 64'h2002, 64'hBEEF, 5'd3, 1'b1, rand64(), 0, 0);
    applyStimulus(4'd3, 64'h1002, 64'h0, 5'd9, 1'b1, rand64(), 0, 0);
    applyStimulus(4'd4, 64'h3000, 64'h0, 5'd12, 1'b1, 64'hFEDC_BA98_7654_3210, 3, 2);
    applyStimulus(4'd11, 64'h4008, 64'h0123_4567_89AB_CDEF, 5'd1, 1'b1, rand64(), 2, 1);
    applyStimulus(4'd14, 64'hDEAD_BEEF, 64'h0, 5'd31, 1'b0, rand64(), 0, 0);

    for (int i = 0; i < 150; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), rand64(), rand64(), 5'($urandom), 1'($urandom),
                    rand64(), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset in the middle of a bus transaction.
    in_valid = 1; in_op = 4'd4; in_addr = 64'h5000; in_rd = 5'd4; in_wen = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    checkOutput("midbus_dreq_valid", dreq_valid, 1);
    reset = 1;
    #1;
    checkOutput("midrst_dreq_valid", dreq_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;
    dresp_ok = 1; dresp_data = rand64();
    @(negedge clk);
    dresp_ok = 0;
    checkOutput("postrst_in_ready", in_ready, 1);
    checkOutput("postrst_out_valid", out_valid, 0);
    checkOutput("postrst_dreq_valid", dreq_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have no parameters; data width is fixed at 64, register index width at 5.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 in_valid  input  1  execute stage presents an instruction.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 in_op  input  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; 12-15 treated as NONE.
REQ-007 in_addr  input  64  ALU result; memory address, or the writeback value for NONE.
REQ-008 in_wdata  input  64  store data, right-aligned.
REQ-009 in_rd  input  5  destination register.
REQ-010 in_wen  input  1  instruction writes in_rd.
REQ-011 dreq_valid  output  1  data-bus request active.
REQ-012 dreq_addr  output  64  request address.
REQ-013 dreq_size  output  3  log2 of access bytes (0..3).
REQ-014 dreq_strobe  output  8  byte write enables; 0 for loads.
REQ-015 dreq_data  output  64  lane-aligned store data.
REQ-016 dresp_ok  input  1  bus completes the request this cycle.
REQ-017 dresp_data  input  64  load data, valid with dresp_ok.
REQ-018 out_valid  output  1  result ready for writeback.
REQ-019 out_ready  input  1  writeback accepts.
REQ-020 out_result  output  64  writeback value.
REQ-021 out_rd  output  5  destination register.
REQ-022 out_wen  output  1  register write enable.
REQ-023 out_misalign  output  1  address misaligned; no access performed.

Function
REQ-024 SHALL implement states IDLE, BUS, OUT; in_ready = (state == IDLE); accept = in_valid & in_ready.
REQ-025 IDLE, accept of NONE: latch out_result = in_addr, out_rd, out_wen = in_wen; go OUT next cycle.
REQ-026 IDLE, accept of memory op with in_addr not a multiple of access size: out_misalign = 1, out_wen = 0, out_result = in_addr; go OUT; dreq_valid stays 0.
REQ-027 IDLE, accept of aligned memory op: latch op, address, rd, wen; go BUS.
REQ-028 BUS: dreq_valid = 1, with dreq_addr/size/strobe/data constant until and including the cycle dresp_ok = 1; on that edge capture formatted data and go OUT.
REQ-029 OUT: out_valid = 1 with outputs stable; out_ready = 1 returns to IDLE on that edge; in_ready remains 0 throughout OUT (no same-cycle bypass).
REQ-030 Latency: accepted at cycle N -> NONE/misaligned out_valid at N+1; memory op dreq_valid at N+1, and dresp_ok at cycle M gives out_valid at M+1.
REQ-031 Load: off = addr[2:0]; raw = dresp_data >> (8*off); LB/LH/LW sign-extend bits 7/15/31; LBU/LHU/LWU zero-extend; LD takes raw; out_wen = latched in_wen.
REQ-032 Store: dreq_data = in_wdata << (8*off); dreq_strobe = ((1 << 2^size) - 1) << off; out_wen = 0; out_result = address.
REQ-033 dresp_ok outside BUS SHALL be ignored; dresp_data is sampled only on the completing edge.
REQ-034 All outputs SHALL be registered or decoded from state only; no combinational path from in_* to dreq_* or out_*.

Reset
REQ-035 reset SHALL force IDLE asynchronously: in_ready = 1; dreq_valid, out_valid, out_wen, out_misalign = 0; all data outputs 0.
REQ-036 reset during BUS SHALL drop dreq_valid in the same cycle; a later dresp_ok has no effect.

Verification
REQ-037 NONE, in_addr = 0x1234, rd = 5, wen = 1 -> next cycle out_valid = 1, out_result = 0x1234, out_rd = 5, out_wen = 1.
REQ-038 LB at 0x1003, dresp_data = 0x0000_0000_8000_0000 -> out_result = 0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
REQ-039 SH at 0x2002, wdata = 0xBEEF -> dreq_strobe = 0x0C, dreq_data = 0xBEEF_0000, dreq_size = 1, out_wen = 0.
REQ-040 LW at 0x1002 -> dreq_valid never asserted, out_misalign = 1, out_wen = 0 at N+1.
REQ-041 LD with dresp_ok delayed 3 cycles, then out_ready held 0 for 2 cycles -> request fields stable for 4 cycles; outputs stable; in_ready = 0 until the out_ready edge.
REQ-042 reset asserted mid-BUS -> dreq_valid = 0 immediately; after release in_ready = 1, out_valid = 0.
